booth_digit_decoder: RTL and testbench

Sequential radix-4 Booth decoder and accumulator: the consumer side of the Booth encoding stage. Accepts a signed multiplicand, then a stream of encoded Booth digits (LSB digit first) over a valid/ready handshake. Decodes each digit into a partial product, shifts it by its digit weight and accumulates it. After the last digit it presents the signed `2*WIDTH`-bit product on a valid/ready output.

---
 rtl/booth_digit_decoder_if.sv | 24 ++
 rtl/booth_digit_decoder.sv | 84 ++++++++
 tb/tb_booth_digit_decoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/booth_digit_decoder_if.sv
// Handshake bundle between a Booth digit producer and the decoder/accumulator.
// master drives start/mcand/digits and consumes the product; slave is the decoder.
interface booth_digit_decoder_if #(parameter int WIDTH = 16);
  logic                 start;
  logic [WIDTH-1:0]     mcand;
  logic                 dig_valid;
  logic                 dig_ready;
  logic [2:0]           dig;
  logic                 prod_valid;
  logic                 prod_ready;
  logic [2*WIDTH-1:0]   prod;
  logic                 busy;
  logic                 err;

  modport master (
    output start, mcand, dig_valid, dig, prod_ready,
    input  dig_ready, prod_valid, prod, busy, err
  );

  modport slave (
    input  start, mcand, dig_valid, dig, prod_ready,
    output dig_ready, prod_valid, prod, busy, err
  );
endinterface

// File: rtl/booth_digit_decoder.sv
// Sequential radix-4 Booth decoder: accumulates one shifted partial product per
// accepted digit (LSB digit first) and presents the signed 2*WIDTH product.
module booth_digit_decoder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_digit_decoder_if.slave  bus
);
  localparam int NDIG = WIDTH / 2;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand_q;
  logic [PW-1:0]    acc_q;
  logic [KW-1:0]    k_q;
  logic             err_q;

  logic [PW-1:0]    mc_ext, pp_base, pp;
  logic             illegal;
  logic             dig_fire, last_dig;

  assign mc_ext   = {{WIDTH{mcand_q[WIDTH-1]}}, mcand_q};
  assign dig_fire = (state == ACC) && bus.dig_valid;
  assign last_dig = (k_q == KW'(NDIG - 1));

  // {neg,two,one}: 011/111 are illegal and contribute nothing.
  always_comb begin
    pp_base = '0;
    illegal = 1'b0;
    case (bus.dig)
      3'b001:         pp_base = mc_ext;
      3'b010:         pp_base = mc_ext << 1;
      3'b101:         pp_base = -mc_ext;
      3'b110:         pp_base = -(mc_ext << 1);
      3'b011, 3'b111: illegal = 1'b1;
      default:        pp_base = '0;
    endcase
  end

  assign pp = pp_base << {k_q, 1'b0};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)        state_nxt = ACC;
      ACC:     if (dig_fire && last_dig) state_nxt = DONE;
      DONE:    if (bus.prod_ready)   state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        mcand_q <= bus.mcand;
        acc_q   <= '0;
        k_q     <= '0;
        err_q   <= 1'b0;
      end else if (dig_fire) begin
        acc_q <= acc_q + pp;
        k_q   <= k_q + KW'(1);
        if (illegal) err_q <= 1'b1;
      end
    end
  end

  // acc_q only moves in ACC, so it is stable for the whole DONE phase.
  assign bus.prod       = acc_q;
  assign bus.err        = err_q;
  assign bus.dig_ready  = (state == ACC);
  assign bus.prod_valid = (state == DONE);
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_booth_digit_decoder.sv
// Directed bench for booth_digit_decoder: hand-computed products, stalls,
// illegal digits and asynchronous reset mid-product.
module tb_booth_digit_decoder;
  localparam int WIDTH = 16;
  localparam logic [2:0] Z  = 3'b000, P1 = 3'b001, P2 = 3'b010;
  localparam logic [2:0] M1 = 3'b101, M2 = 3'b110, BAD = 3'b011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  booth_digit_decoder_if #(.WIDTH(WIDTH)) bus ();

  booth_digit_decoder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full product; digs[0] is sent first. With stall set, dig_valid
  // toggles, junk digits sit on the bus while invalid, start pulses are thrown
  // at ACC/DONE, and prod_ready is withheld for 5 DONE cycles.
  task automatic do_product(input string tag, input logic [15:0] mc,
                            input logic [7:0][2:0] digs, input bit stall,
                            input logic [31:0] exp_p, input bit exp_e);
    logic [31:0] held;
    bus.prod_ready = !stall;
    bus.start = 1'b1;
    bus.mcand = mc;
    tick();
    bus.start = 1'b0;
    bus.mcand = ~mc;
    check({tag, ":busy_acc"}, 64'(bus.busy), 64'd1);
    check({tag, ":ready_acc"}, 64'(bus.dig_ready), 64'd1);
    check({tag, ":err_cleared"}, 64'(bus.err), 64'd0);
    for (int i = 0; i < 8; i++) begin
      if (stall) begin
        bus.dig_valid = 1'b0;
        bus.dig = 3'b111;
        if (i == 2) begin bus.start = 1'b1; bus.mcand = 16'h5555; end
        tick();
        bus.start = 1'b0;
      end
      check({tag, ":no_pv_early"}, 64'(bus.prod_valid), 64'd0);
      bus.dig_valid = 1'b1;
      bus.dig = digs[i];
      tick();
    end
    bus.dig_valid = 1'b0;
    bus.dig = 3'b000;
    check({tag, ":pv_rise"}, 64'(bus.prod_valid), 64'd1);
    check({tag, ":ready_done"}, 64'(bus.dig_ready), 64'd0);
    check({tag, ":prod"}, 64'(bus.prod), 64'(exp_p));
    check({tag, ":err"}, 64'(bus.err), 64'(exp_e));
    held = bus.prod;
    if (stall) begin
      for (int c = 0; c < 5; c++) begin
        bus.start = (c == 1);
        tick();
        check({tag, ":pv_hold"}, 64'(bus.prod_valid), 64'd1);
        check({tag, ":prod_hold"}, 64'(bus.prod), 64'(held));
      end
    end
    bus.prod_ready = 1'b1;
    bus.start = stall;
    tick();
    bus.start = 1'b0;
    bus.prod_ready = 1'b0;
    check({tag, ":idle_after"}, 64'(bus.busy), 64'd0);
    check({tag, ":pv_drop"}, 64'(bus.prod_valid), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mcand = '0;
    bus.dig_valid = 1'b0;
    bus.dig = '0;
    bus.prod_ready = 1'b0;
    #12;
    check("rst:busy", 64'(bus.busy), 64'd0);
    check("rst:dig_ready", 64'(bus.dig_ready), 64'd0);
    check("rst:prod_valid", 64'(bus.prod_valid), 64'd0);
    check("rst:prod", 64'(bus.prod), 64'd0);
    check("rst:err", 64'(bus.err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 3 * 5
    do_product("p3x5", 16'd3, {Z, Z, Z, Z, Z, Z, P1, P1}, 1'b0, 32'h0000000F, 1'b0);
    // -2 * -1
    do_product("m2xm1", 16'hFFFE, {Z, Z, Z, Z, Z, Z, Z, M1}, 1'b0, 32'h00000002, 1'b0);
    // -32768 * -32768
    do_product("min2", 16'h8000, {M2, Z, Z, Z, Z, Z, Z, Z}, 1'b0, 32'h40000000, 1'b0);
    // -7 * 14 with stalls and ignored starts
    do_product("stall", 16'hFFF9, {Z, Z, Z, Z, Z, P1, M1, P2}, 1'b1, 32'hFFFFFF9E, 1'b0);
    // illegal digit at k=2 contributes zero and flags err
    do_product("illegal", 16'd3, {Z, Z, Z, Z, Z, BAD, P1, P1}, 1'b0, 32'h0000000F, 1'b1);
    check("illegal:err_sticky_idle", 64'(bus.err), 64'd1);

    // Reset after 4 accepted digits of 3 * 5
    bus.start = 1'b1;
    bus.mcand = 16'd3;
    tick();
    bus.start = 1'b0;
    check("midrst:err_cleared", 64'(bus.err), 64'd0);
    for (int i = 0; i < 4; i++) begin
      bus.dig_valid = 1'b1;
      bus.dig = (i < 2) ? P1 : Z;
      tick();
    end
    bus.dig_valid = 1'b0;
    check("midrst:acc_before", 64'(bus.prod), 64'h0F);
    rst_n = 1'b0;
    #1;
    check("midrst:busy", 64'(bus.busy), 64'd0);
    check("midrst:dig_ready", 64'(bus.dig_ready), 64'd0);
    check("midrst:prod_valid", 64'(bus.prod_valid), 64'd0);
    check("midrst:prod", 64'(bus.prod), 64'd0);
    check("midrst:err", 64'(bus.err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_product("after_rst", 16'd3, {Z, Z, Z, Z, Z, Z, P1, P1}, 1'b0, 32'h0000000F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
